// File: rtl/tick_sched_pkg.sv
// rtl/tick_sched_pkg.sv - shared types, defaults and width helper for tick_scheduler
// Holds the scheduler state enumeration, default prescale/divisor constants
// and the channel-select width function. No ports.
package tick_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        HALT_PEND = 2'd2
    } sched_state_e;

    localparam int PRESCALE_DEF    = 50000;
    localparam int DIV_DEFAULT_DEF = 500;

    // Select width for num_ch channels; never narrower than one bit.
    function automatic int ch_w(input int num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/tick_channel.sv
// rtl/tick_channel.sv - one programmable tick channel dividing the base tick
// Ports: clk_i/rst_i clock and async active-high reset; run_i high in RUN or
// HALT_PEND; go_idle_i high on the edge entering IDLE; base_i base-tick event
// on this edge; wr_en_i/wr_div_i shadow divisor write; tick_o registered
// channel strobe; sq_o registered square output (only with SQUARE_OUT_EN).
module tick_channel
    import tick_sched_pkg::*;
#(
    parameter int DIV_W       = 10,
    parameter int DIV_DEFAULT = DIV_DEFAULT_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic             go_idle_i,
    input  logic             base_i,
    input  logic             wr_en_i,
    input  logic [DIV_W-1:0] wr_div_i,
    output logic             tick_o
`ifdef SQUARE_OUT_EN
    ,
    output logic             sq_o
`endif
);

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_DEFAULT);

    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic [DIV_W-1:0] active_q, active_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             disabled, tick_ev, copy_ev;

    always_comb begin
        disabled = (active_q == '0);
        tick_ev  = base_i && !disabled && (cnt_q == active_q - DIV_W'(1));
        // A disabled channel never ticks, so it picks up new divisors on any base tick.
        copy_ev  = base_i && pend_q && (tick_ev || disabled);

        shadow_d = wr_en_i ? wr_div_i : shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        tick_d   = tick_ev;
        // A write coinciding with a copy stays pending for the following tick.
        pend_d   = wr_en_i ? 1'b1 : (copy_ev ? 1'b0 : pend_q);

        if (base_i) begin
            cnt_d = (tick_ev || disabled) ? '0 : cnt_q + DIV_W'(1);
        end
        if (copy_ev) begin
            active_d = shadow_q;
            cnt_d    = '0;
        end
        // While stopped the active divisor tracks the shadow directly.
        if (!run_i || go_idle_i) begin
            active_d = shadow_d;
            pend_d   = 1'b0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_q <= DIV_RST;
            active_q <= DIV_RST;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            tick_q   <= tick_d;
        end
    end

    assign tick_o = tick_q;

`ifdef SQUARE_OUT_EN
    logic sq_q, sq_d;

    always_comb begin
        sq_d = sq_q ^ tick_ev;
        if (!run_i || go_idle_i) begin
            sq_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sq_q <= 1'b0;
        end else begin
            sq_q <= sq_d;
        end
    end

    assign sq_o = sq_q;
`endif

endmodule

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - shared prescaler, run/stop FSM and config decode for NUM_CH tick channels
// Ports: clk_i clock; rst_i async active-high reset; start_i/stop_i run control
// levels; cfg_we_i/cfg_sel_i/cfg_div_i divisor write; cfg_ack_o/cfg_err_o
// one-cycle write result; busy_o high in RUN/HALT_PEND; base_tick_o prescaler
// strobe; tick_o per-channel strobes; sq_o square outputs when the
// SQUARE_OUT_EN macro is defined. All outputs are registered.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int  NUM_CH      = 4,
    parameter int  PRE_W       = 16,
    parameter int  PRESCALE    = PRESCALE_DEF,
    parameter int  DIV_W       = 10,
    parameter int  DIV_DEFAULT = DIV_DEFAULT_DEF,
    localparam int CH_W        = ch_w(NUM_CH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              cfg_we_i,
    input  logic [CH_W-1:0]   cfg_sel_i,
    input  logic [DIV_W-1:0]  cfg_div_i,
    output logic              cfg_ack_o,
    output logic              cfg_err_o,
    output logic              busy_o,
    output logic              base_tick_o,
    output logic [NUM_CH-1:0] tick_o
`ifdef SQUARE_OUT_EN
    ,
    output logic [NUM_CH-1:0] sq_o
`endif
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [CH_W:0]    NUM_CH_L = (CH_W+1)'(NUM_CH);

    sched_state_e     state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             base_q, base_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             running, go_idle, cfg_ok;

    // Prescaler: free-runs only while scheduling, held at zero in IDLE.
    always_comb begin
        running = (state_q != IDLE);
        base_d  = running && (pre_q == PRE_LAST);
        pre_d   = (running && !base_d) ? pre_q + PRE_W'(1) : '0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start_i && !stop_i) state_d = RUN;
            RUN:       if (stop_i)             state_d = HALT_PEND;
            HALT_PEND: if (base_d)             state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    always_comb begin
        go_idle = (state_d == IDLE);
        busy_d  = !go_idle;
        cfg_ok  = ({1'b0, cfg_sel_i} < NUM_CH_L);
        ack_d   = cfg_we_i && cfg_ok;
        err_d   = cfg_we_i && !cfg_ok;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pre_q   <= '0;
            base_q  <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            base_q  <= base_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign cfg_ack_o   = ack_q;
    assign cfg_err_o   = err_q;
    assign busy_o      = busy_q;
    assign base_tick_o = base_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        tick_channel #(
            .DIV_W       (DIV_W),
            .DIV_DEFAULT (DIV_DEFAULT)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .run_i     (running),
            .go_idle_i (go_idle),
            .base_i    (base_d),
            .wr_en_i   (cfg_we_i && cfg_ok && (cfg_sel_i == CH_W'(c))),
            .wr_div_i  (cfg_div_i),
            .tick_o    (tick_o[c])
`ifdef SQUARE_OUT_EN
            ,
            .sq_o      (sq_o[c])
`endif
        );
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// tb/tb_tick_scheduler.sv - randomized self-checking bench for tick_scheduler
module tb_tick_scheduler;

    localparam int P   = 4;
    localparam int NCH = 3;
    localparam int DD  = 3;

    logic           clk, rst, start, stop, we;
    logic [1:0]     sel;
    logic [3:0]     div;
    logic           ack, err, busy, base;
    logic [NCH-1:0] tick;
`ifdef SQUARE_OUT_EN
    logic [NCH-1:0] sq;
`endif

    tick_scheduler #(
        .NUM_CH      (NCH),
        .PRE_W       (4),
        .PRESCALE    (P),
        .DIV_W       (4),
        .DIV_DEFAULT (DD)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .stop_i      (stop),
        .cfg_we_i    (we),
        .cfg_sel_i   (sel),
        .cfg_div_i   (div),
        .cfg_ack_o   (ack),
        .cfg_err_o   (err),
        .busy_o      (busy),
        .base_tick_o (base),
        .tick_o      (tick)
`ifdef SQUARE_OUT_EN
        ,
        .sq_o        (sq)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: time since start, base ticks counted per channel since
    // the divisor last took effect, tick whenever that count is a multiple of div.
    int             m_state;
    int             m_cyc;
    int             m_shadow[NCH];
    int             m_active[NCH];
    int             m_nbt[NCH];
    bit             m_pend[NCH];
    bit             e_base, e_busy, e_ack, e_err;
    logic [NCH-1:0] e_tick, e_sq;

    task automatic model_reset();
        m_state = 0;
        m_cyc   = 0;
        for (int c = 0; c < NCH; c++) begin
            m_shadow[c] = DD;
            m_active[c] = DD;
            m_nbt[c]    = 0;
            m_pend[c]   = 1'b0;
        end
        e_base = 0; e_busy = 0; e_ack = 0; e_err = 0;
        e_tick = '0; e_sq = '0;
    endtask

    task automatic model_step();
        bit running, bt;
        int nxt;
        running = (m_state != 0);
        bt      = 1'b0;
        if (running) begin
            m_cyc++;
            bt = ((m_cyc % P) == 0);
        end
        nxt = m_state;
        if (m_state == 0 && start && !stop) nxt = 1;
        else if (m_state == 1 && stop) nxt = 2;
        else if (m_state == 2 && bt) nxt = 0;

        e_tick = '0;
        for (int c = 0; c < NCH; c++) begin
            if (bt && m_active[c] != 0) begin
                m_nbt[c]++;
                if ((m_nbt[c] % m_active[c]) == 0) e_tick[c] = 1'b1;
            end
            if (bt && m_pend[c] && (e_tick[c] || m_active[c] == 0)) begin
                m_active[c] = m_shadow[c];
                m_nbt[c]    = 0;
                m_pend[c]   = 1'b0;
            end
            if (e_tick[c]) e_sq[c] = ~e_sq[c];
        end

        e_ack = we && (int'(sel) < NCH);
        e_err = we && (int'(sel) >= NCH);
        if (e_ack) begin
            m_shadow[int'(sel)] = int'(div);
            m_pend[int'(sel)]   = 1'b1;
        end

        if (m_state == 0 || nxt == 0) begin
            for (int c = 0; c < NCH; c++) begin
                m_active[c] = m_shadow[c];
                m_pend[c]   = 1'b0;
                m_nbt[c]    = 0;
            end
            e_sq  = '0;
            m_cyc = 0;
        end
        m_state = nxt;
        e_base  = bt;
        e_busy  = (nxt != 0);
    endtask

    task automatic compare_all();
        check("base_tick", 32'(base), 32'(e_base));
        check("tick",      32'(tick), 32'(e_tick));
        check("busy",      32'(busy), 32'(e_busy));
        check("cfg_ack",   32'(ack),  32'(e_ack));
        check("cfg_err",   32'(err),  32'(e_err));
`ifdef SQUARE_OUT_EN
        check("sq",        32'(sq),   32'(e_sq));
`endif
    endtask

    task automatic step(input bit s_start, input bit s_stop, input bit s_we,
                        input logic [1:0] s_sel, input logic [3:0] s_div);
        start = s_start;
        stop  = s_stop;
        we    = s_we;
        sel   = s_sel;
        div   = s_div;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 2'd0, 4'd0);
    endtask

    // Reset asserted between edges: outputs must clear before the next edge.
    task automatic async_reset();
        rst = 1'b1;
        #2;
        model_reset();
        compare_all();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 0; stop = 0; we = 0; sel = '0; div = '0;
        model_reset();
        #12;
        compare_all();
        rst = 1'b0;

        step(1, 0, 0, 2'd0, 4'd0);
        idle_steps(30);
        step(0, 0, 1, 2'd1, 4'd1);
        idle_steps(20);
        step(0, 0, 1, 2'd3, 4'd2);
        idle_steps(10);
        step(0, 1, 0, 2'd0, 4'd0);
        idle_steps(8);
        step(1, 1, 0, 2'd0, 4'd0);
        idle_steps(6);
        step(0, 0, 1, 2'd0, 4'd0);
        step(1, 0, 0, 2'd0, 4'd0);
        idle_steps(30);
        async_reset();
        step(1, 0, 0, 2'd0, 4'd0);
        idle_steps(40);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 5)));
            if ($urandom_range(0, 399) == 0) async_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
